mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq_pkg.sv | 43 ++++
 rtl/mix_columns_seq_if.sv | 33 +++
 rtl/mix_column_fwd.sv | 33 +++
 rtl/mix_columns_seq.sv | 106 ++++++++++
 tb/tb_mix_columns_seq.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_seq_pkg.sv
// Shared AES types and GF(2^8) helpers for the MixColumns engine.
// Package aes_pkg: state/column typedefs, FSM encoding, the reduction
// constant and the xtime-based constant multipliers used by both the
// forward and inverse column transforms.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mc_state_e;

  localparam logic [7:0] AES_POLY_RED = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Inverse multipliers are built from x2/x4/x8 chains rather than tables.
  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Valid/ready bus for mix_columns_seq.
// Input side: in_valid, in_ready, in_state (+ inv when MIXCOL_INV_EN).
// Output side: out_valid, out_ready, out_state.
// master = producer/consumer around the block, slave = the block itself.
interface mix_columns_seq_if;
  import aes_pkg::*;

  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;
`ifdef MIXCOL_INV_EN
  logic       inv;
`endif

  modport master (
    output in_valid, in_state, out_ready,
`ifdef MIXCOL_INV_EN
    output inv,
`endif
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
`ifdef MIXCOL_INV_EN
    input  inv,
`endif
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_column_fwd.sv
// Combinational single-column MixColumns (byte 0 = col_i[31:24] = row 0).
// Ports: col_i column in, col_o column out, inv_i (MIXCOL_INV_EN only)
// selects InvMixColumns.
module mix_column_fwd
  import aes_pkg::*;
(
  input  aes_col_t col_i,
`ifdef MIXCOL_INV_EN
  input  logic     inv_i,
`endif
  output aes_col_t col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col_i;

  always_comb begin
    col_o = {gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3,
             a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3,
             a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3),
             gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3)};
`ifdef MIXCOL_INV_EN
    if (inv_i) begin
      col_o = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
               gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
               gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
               gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    end
`endif
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per cycle through a shared
// column transform. IDLE accepts a state, BUSY processes columns 0..3,
// DONE holds the result until out_ready.
// Ports: clk, rst_n (async, active-low), bus (mix_columns_seq_if.slave).
// Optional feature: MIXCOL_INV_EN adds the inv select (latched at accept)
// for InvMixColumns; timing is the same in both builds.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mix_columns_seq_if.slave  bus
);

  mc_state_e  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  aes_state_t in_q, in_d;
  aes_state_t out_q, out_d;
  aes_col_t   col_in, col_out;
`ifdef MIXCOL_INV_EN
  logic       inv_q, inv_d;
`endif

  // Column cnt_q of the latched input; column 0 is the MSB word.
  always_comb begin
    col_in = in_q[127:96];
    case (cnt_q)
      2'd0: col_in = in_q[127:96];
      2'd1: col_in = in_q[95:64];
      2'd2: col_in = in_q[63:32];
      2'd3: col_in = in_q[31:0];
      default: col_in = in_q[127:96];
    endcase
  end

  mix_column_fwd u_col (
    .col_i (col_in),
`ifdef MIXCOL_INV_EN
    .inv_i (inv_q),
`endif
    .col_o (col_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    out_d   = out_q;
`ifdef MIXCOL_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          in_d    = bus.in_state;
`ifdef MIXCOL_INV_EN
          inv_d   = bus.inv;
`endif
          cnt_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        case (cnt_q)
          2'd0: out_d[127:96] = col_out;
          2'd1: out_d[95:64]  = col_out;
          2'd2: out_d[63:32]  = col_out;
          2'd3: out_d[31:0]   = col_out;
          default: ;
        endcase
        // Counter wraps 3 -> 0 on the same edge that enters DONE.
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      in_q    <= '0;
      out_q   <= '0;
`ifdef MIXCOL_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
`ifdef MIXCOL_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_state = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed self-checking bench for mix_columns_seq using FIPS-197 column
// vectors. Inverse-path scenarios are compiled in with MIXCOL_INV_EN.
module tb_mix_columns_seq;
  import aes_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mix_columns_seq_if bus ();

  mix_columns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one state, wait for acceptance and for out_valid, capture the
  // result, then drain it. lat = rising edges from acceptance to out_valid.
  task automatic run_state(input logic [127:0] s, input logic inv_sel,
                           output logic [127:0] res, output int lat);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = s;
`ifdef MIXCOL_INV_EN
    bus.inv = inv_sel;
`endif
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    if (!bus.out_valid) begin
      checks++; failures++;
      $display("FAIL run_state_timeout out_valid=%0b required=1", bus.out_valid);
    end
    res = bus.out_state;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_state = '0;
    bus.out_ready = 1'b0;
`ifdef MIXCOL_INV_EN
    bus.inv = 1'b0;
`endif
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_state !== 128'h0) begin
      failures++;
      $display("FAIL reset_state in_ready=%b out_valid=%b out_state=%h required 1 0 0",
               bus.in_ready, bus.out_valid, bus.out_state);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_column();
    logic [127:0] r; int lat;
    run_state(128'hdb135345_01010101_01010101_01010101, 1'b0, r, lat);
    checks++;
    if (r !== 128'h8e4da1bc_01010101_01010101_01010101) begin
      failures++; $display("FAIL single_column got=%h required=8e4da1bc010101010101010101010101", r);
    end
  endtask

  task automatic test_fips_latency();
    logic [127:0] r; int lat;
    run_state(128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c, 1'b0, r, lat);
    checks++;
    if (r !== 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8) begin
      failures++; $display("FAIL fips_vector got=%h required=9fdc589dc6c6c6c6d5d5d7d64d7ebdf8", r);
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL latency got=%0d required=4", lat);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] r; int lat, n; logic bad;
    // Bring a state to DONE while keeping out_ready low.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = 128'h00000000_ffffffff_db135345_01010101;
    @(posedge clk);
    @(negedge clk);
    bus.in_state = 128'h2d26314c_2d26314c_2d26314c_2d26314c; // must not be taken yet
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_state !== 128'h00000000_ffffffff_8e4da1bc_01010101 ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL backpressure_hold out_state=%h in_ready=%b out_valid=%b required=00000000ffffffff8e4da1bc01010101 0 1",
                           bus.out_state, bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL backpressure_release in_ready=%b out_valid=%b required 1 0",
                           bus.in_ready, bus.out_valid);
    end
    run_state(128'h2d26314c_2d26314c_2d26314c_2d26314c, 1'b0, r, lat);
    checks++;
    if (r !== 128'h4d7ebdf8_4d7ebdf8_4d7ebdf8_4d7ebdf8) begin
      failures++; $display("FAIL backpressure_next got=%h required=4d7ebdf84d7ebdf84d7ebdf84d7ebdf8", r);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] r; int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_state = 128'hdb135345_db135345_db135345_db135345;
    @(posedge clk);            // accept, cnt=0
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk); // cnt now 2
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_state !== 128'h0) begin
      failures++; $display("FAIL reset_mid_busy out_valid=%b in_ready=%b out_state=%h required 0 1 0",
                           bus.out_valid, bus.in_ready, bus.out_state);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_hold out_valid=%b required=0", bus.out_valid);
    end
    rst_n = 1'b1;
    run_state(128'hc6c6c6c6_d4d4d4d5_f20a225c_01010101, 1'b0, r, lat);
    checks++;
    if (r !== 128'hc6c6c6c6_d5d5d7d6_9fdc589d_01010101 || lat !== 4) begin
      failures++; $display("FAIL after_reset got=%h lat=%0d required=c6c6c6c6d5d5d7d69fdc589d01010101 lat=4", r, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin [4] = '{128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5,
                              128'h2d26314c_db135345_ffffffff_00000000,
                              128'h01010101_2d26314c_f20a225c_db135345,
                              128'hd4d4d4d5_c6c6c6c6_db135345_2d26314c};
    logic [127:0] vexp [4] = '{128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6,
                               128'h4d7ebdf8_8e4da1bc_ffffffff_00000000,
                               128'h01010101_4d7ebdf8_9fdc589d_8e4da1bc,
                               128'hd5d5d7d6_c6c6c6c6_8e4da1bc_4d7ebdf8};
    int ni = 0, no = 0, cyc = 0, last = -1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = vin[0];
    ni = 1;
    while (no < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_state !== vexp[no]) begin
          failures++; $display("FAIL stream_result[%0d] got=%h required=%h", no, bus.out_state, vexp[no]);
        end
        // Full cycle is IDLE(accept) + 4 BUSY + DONE with both sides ready.
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 6) begin
            failures++; $display("FAIL stream_spacing got=%0d required=6", cyc - last);
          end
        end
        last = cyc;
        no++;
      end
      if (bus.in_ready) begin
        if (ni < 4) begin bus.in_state = vin[ni]; ni++; end
        else bus.in_valid = 1'b0;
      end
    end
    if (no < 4) begin
      checks++; failures++;
      $display("FAIL stream_timeout results=%0d required=4", no);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (8) @(negedge clk);
  endtask

`ifdef MIXCOL_INV_EN
  task automatic test_inverse();
    logic [127:0] r, f, s; int lat;
    run_state(128'h8e4da1bc_01010101_01010101_01010101, 1'b1, r, lat);
    checks++;
    if (r !== 128'hdb135345_01010101_01010101_01010101 || lat !== 4) begin
      failures++; $display("FAIL inverse_vector got=%h lat=%0d required=db135345010101010101010101010101 lat=4", r, lat);
    end
    for (int i = 0; i < 4; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_state(s, 1'b0, f, lat);
      run_state(f, 1'b1, r, lat);
      checks++;
      if (r !== s) begin
        failures++; $display("FAIL round_trip[%0d] got=%h required=%h", i, r, s);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_column();
    test_fips_latency();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef MIXCOL_INV_EN
    test_inverse();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
